display_pic_scroll: RTL

Parametrised picture-display stage for the VGA path. It maps the controller's (h_addr, v_addr) scan position to an image ROM address, applying integer down-scaling and frame-synchronous scroll offsets. It then expands the ROM colour word to 24-bit RGB with a fixed, valid-tagged pipeline latency. It sits between the VGA timing controller and the VGA output register, with the image ROM external so that it can be swapped or modelled.

---
 rtl/display_pic_scroll_if.sv | 29 ++
 rtl/display_pic_scroll.sv | 109 ++++++++++
 2 files changed

// File: rtl/display_pic_scroll_if.sv
// Scan, scroll, ROM and pixel-out signal bundle for display_pic_scroll.
// The timing controller/testbench side uses master; the picture stage uses slave.
interface display_pic_scroll_if #(
    parameter int unsigned COLOR_BITS = 4,
    parameter int unsigned IMG_W_LOG2 = 10,
    parameter int unsigned IMG_H_LOG2 = 9
) ();
    logic [9:0]                       h_addr;
    logic [9:0]                       v_addr;
    logic                             valid_in;
    logic                             scroll_req;
    logic [IMG_W_LOG2-1:0]            scroll_dx;
    logic [IMG_H_LOG2-1:0]            scroll_dy;
    logic                             scroll_ack;
    logic [IMG_W_LOG2+IMG_H_LOG2-1:0] rom_addr;
    logic [3*COLOR_BITS-1:0]          rom_data;
    logic [23:0]                      data;
    logic                             valid_out;

    modport master (
        output h_addr, v_addr, valid_in, scroll_req, scroll_dx, scroll_dy, rom_data,
        input  scroll_ack, rom_addr, data, valid_out
    );

    modport slave (
        input  h_addr, v_addr, valid_in, scroll_req, scroll_dx, scroll_dy, rom_data,
        output scroll_ack, rom_addr, data, valid_out
    );
endinterface

// File: rtl/display_pic_scroll.sv
// Picture display stage: scan position -> scaled/scrolled ROM address -> 24-bit RGB.
// Define DISPLAY_PIC_EXPAND_EN for bit-replicated channel expansion (default: left-aligned).
module display_pic_scroll #(
    parameter int unsigned COLOR_BITS = 4,
    parameter int unsigned IMG_W_LOG2 = 10,
    parameter int unsigned IMG_H_LOG2 = 9,
    parameter int unsigned SCALE_LOG2 = 0,
    parameter int unsigned ROM_LAT    = 1
) (
    input logic                clk_div,
    input logic                rst,
    display_pic_scroll_if.slave bus
);

    logic [IMG_W_LOG2-1:0] x_q, x_d;
    logic [IMG_H_LOG2-1:0] y_q, y_d;
    logic                  vld_a_q, vld_a_d;
    logic [ROM_LAT-1:0]    vpipe_q, vpipe_d;
    logic [23:0]           data_q, data_d;
    logic                  valid_out_q, valid_out_d;
    logic                  ack_q, ack_d;
    logic [IMG_W_LOG2-1:0] dx_pend_q, dx_pend_d, dx_act_q, dx_act_d;
    logic [IMG_H_LOG2-1:0] dy_pend_q, dy_pend_d, dy_act_q, dy_act_d;
    logic                  pend_q, pend_d;

    logic                  frame_start;
    logic                  activate;
    logic [9:0]            h_sh, v_sh;

    function automatic logic [7:0] expand_ch(input logic [COLOR_BITS-1:0] c);
        logic [7:0] r;
        r = '0;
`ifdef DISPLAY_PIC_EXPAND_EN
        for (int unsigned i = 0; i < 8; i++)
            r[7-i] = c[COLOR_BITS-1-(i % COLOR_BITS)];
`else
        for (int unsigned i = 0; i < COLOR_BITS; i++)
            r[7-i] = c[COLOR_BITS-1-i];
`endif
        return r;
    endfunction

    always_comb begin
        frame_start = bus.valid_in && (bus.h_addr == '0) && (bus.v_addr == '0);
        // A request landing on frame_start replaces the pending offsets and defers activation.
        activate    = frame_start && pend_q && !bus.scroll_req;

        dx_act_d  = activate ? dx_pend_q : dx_act_q;
        dy_act_d  = activate ? dy_pend_q : dy_act_q;
        dx_pend_d = bus.scroll_req ? bus.scroll_dx : dx_pend_q;
        dy_pend_d = bus.scroll_req ? bus.scroll_dy : dy_pend_q;
        pend_d    = bus.scroll_req ? 1'b1 : (activate ? 1'b0 : pend_q);
        ack_d     = activate;

        h_sh    = bus.h_addr >> SCALE_LOG2;
        v_sh    = bus.v_addr >> SCALE_LOG2;
        x_d     = IMG_W_LOG2'(h_sh) + dx_act_d;
        y_d     = IMG_H_LOG2'(v_sh) + dy_act_d;
        vld_a_d = bus.valid_in;

        vpipe_d    = '0;
        vpipe_d[0] = vld_a_q;
        for (int unsigned i = 1; i < ROM_LAT; i++)
            vpipe_d[i] = vpipe_q[i-1];

        valid_out_d = vpipe_q[ROM_LAT-1];
        data_d      = '0;
        if (vpipe_q[ROM_LAT-1])
            data_d = {expand_ch(bus.rom_data[3*COLOR_BITS-1 -: COLOR_BITS]),
                      expand_ch(bus.rom_data[2*COLOR_BITS-1 -: COLOR_BITS]),
                      expand_ch(bus.rom_data[COLOR_BITS-1:0])};
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            y_q         <= '0;
            vld_a_q     <= 1'b0;
            vpipe_q     <= '0;
            data_q      <= '0;
            valid_out_q <= 1'b0;
            ack_q       <= 1'b0;
            dx_pend_q   <= '0;
            dy_pend_q   <= '0;
            dx_act_q    <= '0;
            dy_act_q    <= '0;
            pend_q      <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            vld_a_q     <= vld_a_d;
            vpipe_q     <= vpipe_d;
            data_q      <= data_d;
            valid_out_q <= valid_out_d;
            ack_q       <= ack_d;
            dx_pend_q   <= dx_pend_d;
            dy_pend_q   <= dy_pend_d;
            dx_act_q    <= dx_act_d;
            dy_act_q    <= dy_act_d;
            pend_q      <= pend_d;
        end
    end

    assign bus.rom_addr   = {x_q, y_q};
    assign bus.data       = data_q;
    assign bus.valid_out  = valid_out_q;
    assign bus.scroll_ack = ack_q;

endmodule
